// File: rtl/shift_deser.sv
// Serial-in/parallel-out deserializer at the receive end of a bit shift chain.
// Aligns to a frame-start strobe and hands words out through a one-entry valid/ready register.
module shift_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     bit_valid_i,
  input  logic                     data_i,
  input  logic                     frame_start_i,
  input  logic                     clear_i,
  output logic [WIDTH-1:0]         word_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     overflow_o,
  output logic [$clog2(WIDTH)-1:0] bit_cnt_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  typedef enum logic [0:0] {StSync, StCollect} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              word_done;
  logic [WIDTH-1:0]  full_word;
  logic [WIDTH-1:0]  first_word;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    logic [WIDTH-1:0] res;
    if (MSB_FIRST) begin
      res = {cur[WIDTH-2:0], b};
    end else begin
      res = {b, cur[WIDTH-1:1]};
    end
    return res;
  endfunction

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StSync;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StSync;
    end else if (bit_valid_i && frame_start_i) begin
      state_d = StCollect;
    end
  end

  // Datapath and output-register next state
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    word_done  = 1'b0;
    full_word  = shift_in(shift_q, data_i);
    first_word = shift_in('0, data_i);

    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (bit_valid_i) begin
        if (frame_start_i) begin
          // Realignment wins even over a word that would complete on this bit.
          shift_d = first_word;
          cnt_d   = OneCnt;
        end else if (state_q == StCollect) begin
          if (cnt_q == LastCnt) begin
            word_done = 1'b1;
            shift_d   = '0;
            cnt_d     = '0;
          end else begin
            shift_d = full_word;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end

      if (word_done) begin
        if (!valid_q || ready_i) begin
          word_d  = full_word;
          valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign word_o     = word_q;
  assign valid_o    = valid_q;
  assign overflow_o = ovf_q;
  assign bit_cnt_o  = cnt_q;

endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser: MSB-first and LSB-first instances on one stream, checked against a
// queue-based word model plus directed scenarios and random traffic.
module tb_shift_deser;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       bit_valid, data, frame_start, clear, ready;
  logic [7:0] word_msb, word_lsb;
  logic       valid_msb, valid_lsb, ovf_msb, ovf_lsb;
  logic [2:0] cnt_msb, cnt_lsb;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: bits of the current aligned word in arrival order.
  bit         m_aligned;
  bit         m_bits[$];
  logic [7:0] m_word_msb, m_word_lsb;
  bit         m_valid, m_ovf;

  always #5 clk = ~clk;

  shift_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .bit_valid_i  (bit_valid),
    .data_i       (data),
    .frame_start_i(frame_start),
    .clear_i      (clear),
    .word_o       (word_msb),
    .valid_o      (valid_msb),
    .ready_i      (ready),
    .overflow_o   (ovf_msb),
    .bit_cnt_o    (cnt_msb)
  );

  shift_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .bit_valid_i  (bit_valid),
    .data_i       (data),
    .frame_start_i(frame_start),
    .clear_i      (clear),
    .word_o       (word_lsb),
    .valid_o      (valid_lsb),
    .ready_i      (ready),
    .overflow_o   (ovf_lsb),
    .bit_cnt_o    (cnt_lsb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_aligned  = 1'b0;
    m_bits.delete();
    m_word_msb = '0;
    m_word_lsb = '0;
    m_valid    = 1'b0;
    m_ovf      = 1'b0;
  endtask

  task automatic model_step(input bit bv, input bit d, input bit fs, input bit clr, input bit rdy);
    bit         consumed;
    bit         complete;
    logic [7:0] wm, wl;
    complete = 1'b0;
    wm = '0;
    wl = '0;
    if (clr) begin
      m_aligned = 1'b0;
      m_bits.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      consumed = m_valid && rdy;
      if (bv) begin
        if (fs) begin
          m_bits.delete();
          m_bits.push_back(d);
          m_aligned = 1'b1;
        end else if (m_aligned) begin
          m_bits.push_back(d);
          if (m_bits.size() == 8) begin
            complete = 1'b1;
            for (int i = 0; i < 8; i++) begin
              wm[7-i] = m_bits[i];
              wl[i]   = m_bits[i];
            end
            m_bits.delete();
          end
        end
      end
      if (complete) begin
        if (!m_valid || rdy) begin
          m_word_msb = wm;
          m_word_lsb = wl;
          m_valid    = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (consumed) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("msb.valid", valid_msb, m_valid);
    check("lsb.valid", valid_lsb, m_valid);
    check("msb.word", word_msb, m_word_msb);
    check("lsb.word", word_lsb, m_word_lsb);
    check("msb.ovf", ovf_msb, m_ovf);
    check("lsb.ovf", ovf_lsb, m_ovf);
    check("msb.cnt", cnt_msb, m_bits.size());
    check("lsb.cnt", cnt_lsb, m_bits.size());
  endtask

  task automatic cyc(input bit bv, input bit d, input bit fs, input bit clr, input bit rdy);
    bit_valid   = bv;
    data        = d;
    frame_start = fs;
    clear       = clr;
    ready       = rdy;
    @(posedge clk);
    model_step(bv, d, fs, clr, rdy);
    @(negedge clk);
    compare_all();
  endtask

  // Sends w in stream order w[7] first.
  task automatic send_word(input logic [7:0] w, input bit framed, input bit rdy, input bit rdy_last);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, w[7-i], framed && (i == 0), 1'b0, (i == 7) ? rdy_last : rdy);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    bit_valid   = 1'b0;
    data        = 1'b0;
    frame_start = 1'b0;
    clear       = 1'b0;
    ready       = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    compare_all();
    check("reset.word", word_msb, 8'h00);

    // Framed B2, ready high: valid for exactly one cycle
    send_word(8'hB2, 1'b1, 1'b1, 1'b1);
    check("b2.msb", word_msb, 8'hB2);
    check("b2.lsb", word_lsb, 8'h4D);
    check("b2.valid", valid_msb, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("b2.valid_drop", valid_msb, 1'b0);

    // Unframed ones ignored in SYNC, then framed 3C
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word(8'hFF, 1'b0, 1'b1, 1'b1);
    check("sync.cnt", cnt_msb, 3'd0);
    check("sync.valid", valid_msb, 1'b0);
    send_word(8'h3C, 1'b1, 1'b1, 1'b1);
    check("3c.msb", word_msb, 8'h3C);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-pressure: A5 held, 5A dropped
    send_word(8'hA5, 1'b1, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    check("bp.word", word_msb, 8'hA5);
    check("bp.valid", valid_msb, 1'b1);
    check("bp.ovf", ovf_msb, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bp.accept", valid_msb, 1'b0);
    check("bp.ovf_sticky", ovf_lsb, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp.clear_ovf", ovf_msb, 1'b0);

    // Back-to-back handoff 01 -> 02
    send_word(8'h01, 1'b1, 1'b0, 1'b0);
    check("ho.first", word_msb, 8'h01);
    send_word(8'h02, 1'b0, 1'b0, 1'b1);
    check("ho.second", word_msb, 8'h02);
    check("ho.valid", valid_msb, 1'b1);
    check("ho.ovf", ovf_msb, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Realignment on the 5th bit
    send_word(8'hF0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send_word(8'hC3, 1'b1, 1'b1, 1'b1);
    check("realign.word", word_msb, 8'hC3);
    check("realign.valid", valid_msb, 1'b1);
    check("realign.ovf", ovf_msb, 1'b0);

    // Async reset pulse mid-word
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    check("areset.word", word_msb, 8'h00);
    check("areset.valid", valid_msb, 1'b0);
    check("areset.cnt", cnt_msb, 3'd0);
    compare_all();
    #2 reset_n = 1'b1;
    @(negedge clk);
    compare_all();
    send_word(8'h6B, 1'b0, 1'b1, 1'b1);
    check("areset.sync_cnt", cnt_msb, 3'd0);
    check("areset.sync_valid", valid_lsb, 1'b0);
    send_word(8'h96, 1'b1, 1'b1, 1'b1);
    check("areset.resume", word_msb, 8'h96);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom % 4) != 0, $urandom % 2, ($urandom % 16) == 0, ($urandom % 64) == 0,
          $urandom % 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
